// File: rtl/building_stripe_edge_scan.sv
// building_stripe_edge_scan
//
// Scans one line (SCAN_ROW) of a binarised pixel stream per frame for
// black/white stripe edges. It reports the first edge of each direction in
// slots 7..10, the outer edge bounds and their slot indices. All results are
// latched at the end of the frame and held for the whole next frame.
//
// Optional feature: define STRIPE_EDGE_COUNT_EN to add the saturating edge
// counters count_w_b / count_b_w.
//
// Ports
//   clk, reset                 pixel clock, synchronous active-high reset
//   in_valid                   pixel beat valid (no backpressure)
//   in_sop / in_eop            first / last pixel of frame (qualified by in_valid)
//   in_white                   binarised pixel, 1 = white
//   f_slot_N_blackToWhite      N=7..10, x of first confirmed B->W edge in slot N, 0 = none
//   f_slot_N_whiteToBlack      N=7..10, x of first confirmed W->B edge in slot N, 0 = none
//   left_most_bound            x of first confirmed edge in the row, 0 = none
//   right_most_bound           x of last confirmed edge in the row, 0 = none
//   left_slot / right_slot     bound / SLOT_W
//   center_slot                ((left + right) >> 1) / SLOT_W
//   count_w_b / count_b_w      (optional) confirmed edge counts, saturating at 31
//   frame_done                 one-cycle pulse when the outputs above were updated
module building_stripe_edge_scan #(
  parameter int IMAGE_W  = 640,
  parameter int IMAGE_H  = 480,
  parameter int SCAN_ROW = 240,
  parameter int SLOT_W   = 40,
  parameter int MIN_RUN  = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic        in_white,
  output logic [10:0] f_slot_7_blackToWhite,
  output logic [10:0] f_slot_7_whiteToBlack,
  output logic [10:0] f_slot_8_blackToWhite,
  output logic [10:0] f_slot_8_whiteToBlack,
  output logic [10:0] f_slot_9_blackToWhite,
  output logic [10:0] f_slot_9_whiteToBlack,
  output logic [10:0] f_slot_10_blackToWhite,
  output logic [10:0] f_slot_10_whiteToBlack,
  output logic [10:0] left_most_bound,
  output logic [10:0] right_most_bound,
  output logic [4:0]  left_slot,
  output logic [4:0]  right_slot,
  output logic [4:0]  center_slot,
`ifdef STRIPE_EDGE_COUNT_EN
  output logic [4:0]  count_w_b,
  output logic [4:0]  count_b_w,
`endif
  output logic        frame_done
);

  localparam logic [10:0] X_LAST     = 11'(IMAGE_W - 1);
  localparam logic [10:0] Y_SCAN     = 11'(SCAN_ROW);
  localparam logic [10:0] Y_LIMIT    = 11'(IMAGE_H);
  localparam logic [10:0] SLOT_DIV   = 11'(SLOT_W);
  localparam logic [3:0]  RUN_NEED   = 4'(MIN_RUN);
  localparam int          FIRST_SLOT = 7;

  typedef enum logic [1:0] {
    WAIT_SOP = 2'd0,
    PRE_ROW  = 2'd1,
    ROW      = 2'd2,
    POST_ROW = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [10:0] x_q, x_d;
  logic [10:0] y_q, y_d;

  // Working registers for the frame currently being scanned.
  logic        ref_q, ref_d;
  logic        cand_act_q, cand_act_d;
  logic [3:0]  run_q, run_d;
  logic [10:0] cand_x_q, cand_x_d;
  logic [10:0] b2w_q [4];
  logic [10:0] b2w_d [4];
  logic [10:0] w2b_q [4];
  logic [10:0] w2b_d [4];
  logic [10:0] left_q, left_d;
  logic [10:0] right_q, right_d;

  // Latched outputs.
  logic [10:0] o_b2w_q [4];
  logic [10:0] o_b2w_d [4];
  logic [10:0] o_w2b_q [4];
  logic [10:0] o_w2b_d [4];
  logic [10:0] o_left_q, o_left_d;
  logic [10:0] o_right_q, o_right_d;
  logic [4:0]  o_lslot_q, o_lslot_d;
  logic [4:0]  o_rslot_q, o_rslot_d;
  logic [4:0]  o_cslot_q, o_cslot_d;
  logic        frame_done_q, frame_done_d;

`ifdef STRIPE_EDGE_COUNT_EN
  logic [4:0]  cnt_w_b_q, cnt_w_b_d;
  logic [4:0]  cnt_b_w_q, cnt_b_w_d;
  logic [4:0]  o_cnt_w_b_q, o_cnt_w_b_d;
  logic [4:0]  o_cnt_b_w_q, o_cnt_b_w_d;
`endif

  logic [10:0] cur_x_s;
  logic [10:0] cur_y_s;
  logic        beat_s;
  state_t      eff_state_s;
  logic        row_beat_s;
  logic [3:0]  new_run_s;
  logic [10:0] pos_s;
  logic [10:0] slot_s;
  logic        confirm_s;
  logic [11:0] sum_s;
  logic [10:0] mid_s;

  // Next-state logic: pixel position, FSM, edge detection and end-of-frame latch.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    ref_d        = ref_q;
    cand_act_d   = cand_act_q;
    run_d        = run_q;
    cand_x_d     = cand_x_q;
    left_d       = left_q;
    right_d      = right_q;
    o_left_d     = o_left_q;
    o_right_d    = o_right_q;
    o_lslot_d    = o_lslot_q;
    o_rslot_d    = o_rslot_q;
    o_cslot_d    = o_cslot_q;
    frame_done_d = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b2w_d[i]   = b2w_q[i];
      w2b_d[i]   = w2b_q[i];
      o_b2w_d[i] = o_b2w_q[i];
      o_w2b_d[i] = o_w2b_q[i];
    end
`ifdef STRIPE_EDGE_COUNT_EN
    cnt_w_b_d   = cnt_w_b_q;
    cnt_b_w_d   = cnt_b_w_q;
    o_cnt_w_b_d = o_cnt_w_b_q;
    o_cnt_b_w_d = o_cnt_b_w_q;
`endif

    // The sop beat is always pixel (0,0) of a fresh frame.
    cur_x_s     = in_sop ? 11'd0 : x_q;
    cur_y_s     = in_sop ? 11'd0 : y_q;
    beat_s      = in_valid && (cur_y_s < Y_LIMIT);
    eff_state_s = in_sop ? PRE_ROW : state_q;
    // The first beat of the scan line is handled as a ROW beat while still in PRE_ROW.
    row_beat_s  = beat_s && ((eff_state_s == PRE_ROW) || (eff_state_s == ROW)) &&
                  (cur_y_s == Y_SCAN);
    new_run_s   = cand_act_q ? (run_q + 4'd1) : 4'd1;
    pos_s       = cand_act_q ? cand_x_q : cur_x_s;
    slot_s      = pos_s / SLOT_DIV;
    confirm_s   = 1'b0;
    sum_s       = 12'd0;
    mid_s       = 11'd0;

    if (beat_s) begin
      if (cur_x_s == X_LAST) begin
        x_d = 11'd0;
        y_d = cur_y_s + 11'd1;
      end else begin
        x_d = cur_x_s + 11'd1;
        y_d = cur_y_s;
      end

      if (in_sop) begin
        ref_d      = 1'b0;
        cand_act_d = 1'b0;
        run_d      = 4'd0;
        cand_x_d   = 11'd0;
        left_d     = 11'd0;
        right_d    = 11'd0;
        for (int i = 0; i < 4; i++) begin
          b2w_d[i] = 11'd0;
          w2b_d[i] = 11'd0;
        end
`ifdef STRIPE_EDGE_COUNT_EN
        cnt_w_b_d = 5'd0;
        cnt_b_w_d = 5'd0;
`endif
      end else begin
        cand_x_d = cand_x_q;
      end

      if (row_beat_s) begin
        if (cur_x_s == 11'd0) begin
          // First pixel only establishes the reference colour.
          ref_d      = in_white;
          cand_act_d = 1'b0;
          run_d      = 4'd0;
        end else if (in_white != ref_q) begin
          if (new_run_s == RUN_NEED) begin
            confirm_s  = 1'b1;
            ref_d      = in_white;
            cand_act_d = 1'b0;
            run_d      = 4'd0;
          end else begin
            cand_act_d = 1'b1;
            run_d      = new_run_s;
            cand_x_d   = pos_s;
          end
        end else begin
          // Colour reverted: drop any pending candidate.
          cand_act_d = 1'b0;
          run_d      = 4'd0;
        end
      end else begin
        confirm_s = 1'b0;
      end

      if (confirm_s) begin
        for (int i = 0; i < 4; i++) begin
          if (slot_s == 11'(FIRST_SLOT + i)) begin
            if (in_white && (b2w_q[i] == 11'd0)) begin
              b2w_d[i] = pos_s;
            end else if (!in_white && (w2b_q[i] == 11'd0)) begin
              w2b_d[i] = pos_s;
            end else begin
              b2w_d[i] = b2w_q[i];
            end
          end else begin
            w2b_d[i] = w2b_q[i];
          end
        end
        if (left_q == 11'd0) begin
          left_d = pos_s;
        end else begin
          left_d = left_q;
        end
        right_d = pos_s;
`ifdef STRIPE_EDGE_COUNT_EN
        if (in_white) begin
          cnt_b_w_d = (cnt_b_w_q == 5'd31) ? 5'd31 : (cnt_b_w_q + 5'd1);
        end else begin
          cnt_w_b_d = (cnt_w_b_q == 5'd31) ? 5'd31 : (cnt_w_b_q + 5'd1);
        end
`endif
      end else begin
        right_d = right_d;
      end

      if (in_eop) begin
        state_d = WAIT_SOP;
      end else if (row_beat_s) begin
        state_d = (cur_x_s == X_LAST) ? POST_ROW : ROW;
      end else begin
        state_d = eff_state_s;
      end

      // Latch uses the _d values so the eop pixel itself is included.
      if (in_eop) begin
        frame_done_d = 1'b1;
        for (int i = 0; i < 4; i++) begin
          o_b2w_d[i] = b2w_d[i];
          o_w2b_d[i] = w2b_d[i];
        end
        o_left_d  = left_d;
        o_right_d = right_d;
        sum_s     = {1'b0, left_d} + {1'b0, right_d};
        mid_s     = 11'(sum_s >> 1);
        o_lslot_d = 5'(left_d / SLOT_DIV);
        o_rslot_d = 5'(right_d / SLOT_DIV);
        o_cslot_d = 5'(mid_s / SLOT_DIV);
`ifdef STRIPE_EDGE_COUNT_EN
        o_cnt_w_b_d = cnt_w_b_d;
        o_cnt_b_w_d = cnt_b_w_d;
`endif
      end else begin
        frame_done_d = 1'b0;
      end
    end else begin
      frame_done_d = 1'b0;
    end
  end

  // State, counters, working registers and latched outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= WAIT_SOP;
      x_q          <= 11'd0;
      y_q          <= 11'd0;
      ref_q        <= 1'b0;
      cand_act_q   <= 1'b0;
      run_q        <= 4'd0;
      cand_x_q     <= 11'd0;
      left_q       <= 11'd0;
      right_q      <= 11'd0;
      o_left_q     <= 11'd0;
      o_right_q    <= 11'd0;
      o_lslot_q    <= 5'd0;
      o_rslot_q    <= 5'd0;
      o_cslot_q    <= 5'd0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        b2w_q[i]   <= 11'd0;
        w2b_q[i]   <= 11'd0;
        o_b2w_q[i] <= 11'd0;
        o_w2b_q[i] <= 11'd0;
      end
`ifdef STRIPE_EDGE_COUNT_EN
      cnt_w_b_q   <= 5'd0;
      cnt_b_w_q   <= 5'd0;
      o_cnt_w_b_q <= 5'd0;
      o_cnt_b_w_q <= 5'd0;
`endif
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      ref_q        <= ref_d;
      cand_act_q   <= cand_act_d;
      run_q        <= run_d;
      cand_x_q     <= cand_x_d;
      left_q       <= left_d;
      right_q      <= right_d;
      o_left_q     <= o_left_d;
      o_right_q    <= o_right_d;
      o_lslot_q    <= o_lslot_d;
      o_rslot_q    <= o_rslot_d;
      o_cslot_q    <= o_cslot_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < 4; i++) begin
        b2w_q[i]   <= b2w_d[i];
        w2b_q[i]   <= w2b_d[i];
        o_b2w_q[i] <= o_b2w_d[i];
        o_w2b_q[i] <= o_w2b_d[i];
      end
`ifdef STRIPE_EDGE_COUNT_EN
      cnt_w_b_q   <= cnt_w_b_d;
      cnt_b_w_q   <= cnt_b_w_d;
      o_cnt_w_b_q <= o_cnt_w_b_d;
      o_cnt_b_w_q <= o_cnt_b_w_d;
`endif
    end
  end

  assign f_slot_7_blackToWhite  = o_b2w_q[0];
  assign f_slot_8_blackToWhite  = o_b2w_q[1];
  assign f_slot_9_blackToWhite  = o_b2w_q[2];
  assign f_slot_10_blackToWhite = o_b2w_q[3];
  assign f_slot_7_whiteToBlack  = o_w2b_q[0];
  assign f_slot_8_whiteToBlack  = o_w2b_q[1];
  assign f_slot_9_whiteToBlack  = o_w2b_q[2];
  assign f_slot_10_whiteToBlack = o_w2b_q[3];
  assign left_most_bound        = o_left_q;
  assign right_most_bound       = o_right_q;
  assign left_slot              = o_lslot_q;
  assign right_slot             = o_rslot_q;
  assign center_slot            = o_cslot_q;
  assign frame_done             = frame_done_q;
`ifdef STRIPE_EDGE_COUNT_EN
  assign count_w_b              = o_cnt_w_b_q;
  assign count_b_w              = o_cnt_b_w_q;
`endif

endmodule

// File: tb/tb_building_stripe_edge_scan.sv
module tb_building_stripe_edge_scan;

  localparam int W   = 640;
  localparam int H   = 4;
  localparam int ROW = 2;

  logic clk = 1'b0;
  logic reset, in_valid, in_sop, in_eop, in_white;

  logic [10:0] d0_b2w [4];
  logic [10:0] d0_w2b [4];
  logic [10:0] d0_left, d0_right;
  logic [4:0]  d0_ls, d0_rs, d0_cs, d0_cwb, d0_cbw;
  logic        d0_done;
  logic [10:0] d1_b2w [4];
  logic [10:0] d1_w2b [4];
  logic [10:0] d1_left, d1_right;
  logic [4:0]  d1_ls, d1_rs, d1_cs, d1_cwb, d1_cbw;
  logic        d1_done;

  typedef struct {
    int b2w[4];
    int w2b[4];
    int left;
    int right;
    int ls;
    int rs;
    int cs;
    int cbw;
    int cwb;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  logic row_pix [W];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;
  int   gap_cnt = 0;
  int   last_left0 = 0;

  always #5 clk = ~clk;

  building_stripe_edge_scan #(.IMAGE_W(W), .IMAGE_H(H), .SCAN_ROW(ROW), .SLOT_W(40), .MIN_RUN(3)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_white(in_white),
    .f_slot_7_blackToWhite(d0_b2w[0]), .f_slot_7_whiteToBlack(d0_w2b[0]),
    .f_slot_8_blackToWhite(d0_b2w[1]), .f_slot_8_whiteToBlack(d0_w2b[1]),
    .f_slot_9_blackToWhite(d0_b2w[2]), .f_slot_9_whiteToBlack(d0_w2b[2]),
    .f_slot_10_blackToWhite(d0_b2w[3]), .f_slot_10_whiteToBlack(d0_w2b[3]),
    .left_most_bound(d0_left), .right_most_bound(d0_right),
    .left_slot(d0_ls), .right_slot(d0_rs), .center_slot(d0_cs),
`ifdef STRIPE_EDGE_COUNT_EN
    .count_w_b(d0_cwb), .count_b_w(d0_cbw),
`endif
    .frame_done(d0_done)
  );

  building_stripe_edge_scan #(.IMAGE_W(W), .IMAGE_H(H), .SCAN_ROW(ROW), .SLOT_W(40), .MIN_RUN(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_white(in_white),
    .f_slot_7_blackToWhite(d1_b2w[0]), .f_slot_7_whiteToBlack(d1_w2b[0]),
    .f_slot_8_blackToWhite(d1_b2w[1]), .f_slot_8_whiteToBlack(d1_w2b[1]),
    .f_slot_9_blackToWhite(d1_b2w[2]), .f_slot_9_whiteToBlack(d1_w2b[2]),
    .f_slot_10_blackToWhite(d1_b2w[3]), .f_slot_10_whiteToBlack(d1_w2b[3]),
    .left_most_bound(d1_left), .right_most_bound(d1_right),
    .left_slot(d1_ls), .right_slot(d1_rs), .center_slot(d1_cs),
`ifdef STRIPE_EDGE_COUNT_EN
    .count_w_b(d1_cwb), .count_b_w(d1_cbw),
`endif
    .frame_done(d1_done)
  );

`ifndef STRIPE_EDGE_COUNT_EN
  assign d0_cwb = 5'd0;
  assign d0_cbw = 5'd0;
  assign d1_cwb = 5'd0;
  assign d1_cbw = 5'd0;
`endif

  task automatic chk(input string tag, input int obs, input int expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input int l, input int r, input int ls, input int rs, input int cs,
                              input int cbw, input int cwb);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.b2w[i] = 0;
      e.w2b[i] = 0;
    end
    e.left = l; e.right = r; e.ls = ls; e.rs = rs; e.cs = cs; e.cbw = cbw; e.cwb = cwb;
    return e;
  endfunction

  task automatic cmp(input string tag, input exp_t e, input exp_t o);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s.slot%0d_b2w", tag, 7 + i), o.b2w[i], e.b2w[i]);
      chk($sformatf("%s.slot%0d_w2b", tag, 7 + i), o.w2b[i], e.w2b[i]);
    end
    chk({tag, ".left"}, o.left, e.left);
    chk({tag, ".right"}, o.right, e.right);
    chk({tag, ".left_slot"}, o.ls, e.ls);
    chk({tag, ".right_slot"}, o.rs, e.rs);
    chk({tag, ".center_slot"}, o.cs, e.cs);
`ifdef STRIPE_EDGE_COUNT_EN
    chk({tag, ".count_b_w"}, o.cbw, e.cbw);
    chk({tag, ".count_w_b"}, o.cwb, e.cwb);
`endif
  endtask

  // Scoreboard: pop the expected record whenever a DUT reports a finished frame.
  always @(negedge clk) begin
    exp_t e, o;
    if (d0_done === 1'b1) begin
      if (q0.size() == 0) chk("d0.unexpected_done", 1, 0);
      else begin
        e = q0.pop_front();
        for (int i = 0; i < 4; i++) begin o.b2w[i] = int'(d0_b2w[i]); o.w2b[i] = int'(d0_w2b[i]); end
        o.left = d0_left; o.right = d0_right; o.ls = d0_ls; o.rs = d0_rs; o.cs = d0_cs;
        o.cbw = d0_cbw; o.cwb = d0_cwb;
        cmp("d0", e, o);
      end
    end
    if (d1_done === 1'b1) begin
      if (q1.size() == 0) chk("d1.unexpected_done", 1, 0);
      else begin
        e = q1.pop_front();
        for (int i = 0; i < 4; i++) begin o.b2w[i] = int'(d1_b2w[i]); o.w2b[i] = int'(d1_w2b[i]); end
        o.left = d1_left; o.right = d1_right; o.ls = d1_ls; o.rs = d1_rs; o.cs = d1_cs;
        o.cbw = d1_cbw; o.cwb = d1_cwb;
        cmp("d1", e, o);
      end
    end
  end

  task automatic row_fill(input int a, input int b, input logic v);
    for (int x = a; x <= b; x++) row_pix[x] = v;
  endtask

  // Drive beats from (0,0) to (last_y,last_x); the scan line uses row_pix, other lines are random.
  task automatic send_frame(input int last_y, input int last_x, input bit with_eop);
    for (int y = 0; y <= last_y; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == last_y && x > last_x) break;
        gap_cnt++;
        if (gap_cnt % 7 == 3) begin
          @(negedge clk);
          in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        end
        @(negedge clk);
        if (y == 1 && x == 0) chk("hold.left", int'(d0_left), last_left0);
        in_valid = 1'b1;
        in_sop   = (x == 0 && y == 0);
        in_eop   = with_eop && (y == last_y) && (x == last_x);
        in_white = (y == ROW) ? row_pix[x] : 1'($urandom_range(0, 1));
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    if (with_eop) begin
      chk("done.latency0", int'(d0_done), 1);
      chk("done.latency1", int'(d1_done), 1);
      @(negedge clk);
      chk("done.pulse0", int'(d0_done), 0);
      chk("done.pulse1", int'(d1_done), 0);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0; in_white = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.left", int'(d0_left), 0);
    chk("rst.right", int'(d0_right), 0);
    chk("rst.slot7_b2w", int'(d0_b2w[0]), 0);
    chk("rst.center", int'(d0_cs), 0);
    chk("rst.done", int'(d0_done), 0);
    reset = 1'b0;

    // Single white bar 300..339.
    row_fill(0, W - 1, 1'b0); row_fill(300, 339, 1'b1);
    e = mk(300, 340, 7, 8, 8, 1, 1); e.b2w[0] = 300; e.w2b[1] = 340;
    q0.push_back(e); q1.push_back(e);
    send_frame(H - 1, W - 1, 1'b1);
    last_left0 = 300;

    // Frame ending before the scan line.
    e = mk(0, 0, 0, 0, 0, 0, 0);
    q0.push_back(e); q1.push_back(e);
    send_frame(1, 200, 1'b1);
    last_left0 = 0;

    // Four 20-px white stripes from 280.
    row_fill(0, W - 1, 1'b0);
    for (int k = 0; k < 4; k++) row_fill(280 + 40 * k, 299 + 40 * k, 1'b1);
    e = mk(280, 420, 7, 10, 8, 4, 4);
    e.b2w[0] = 280; e.b2w[1] = 320; e.b2w[2] = 360; e.b2w[3] = 400;
    e.w2b[0] = 300; e.w2b[1] = 340; e.w2b[2] = 380; e.w2b[3] = 420;
    q0.push_back(e); q1.push_back(e);
    send_frame(H - 1, W - 1, 1'b1);
    last_left0 = 280;

    // 2-px glitch: rejected with MIN_RUN=3, two edges with MIN_RUN=1.
    row_fill(0, W - 1, 1'b0); row_fill(100, 101, 1'b1);
    q0.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    q1.push_back(mk(100, 102, 2, 2, 2, 1, 1));
    send_frame(H - 1, W - 1, 1'b1);
    last_left0 = 0;

    // 8-px stripes over the whole line: counters saturate.
    for (int x = 0; x < W; x++) row_pix[x] = ((x / 8) % 2) == 1;
    e = mk(8, 632, 0, 15, 8, 31, 31);
    e.b2w[0] = 280; e.b2w[1] = 328; e.b2w[2] = 360; e.b2w[3] = 408;
    e.w2b[0] = 288; e.w2b[1] = 320; e.w2b[2] = 368; e.w2b[3] = 400;
    q0.push_back(e); q1.push_back(e);
    send_frame(H - 1, W - 1, 1'b1);
    last_left0 = 8;

    // Edge confirmed on the eop beat itself (eop at end of scan line).
    row_fill(0, W - 1, 1'b0); row_fill(637, 639, 1'b1);
    e = mk(637, 637, 15, 15, 15, 1, 0);
    q0.push_back(e); q1.push_back(e);
    send_frame(ROW, W - 1, 1'b1);
    last_left0 = 637;

    // Reset mid-row after two confirmed edges.
    row_fill(0, W - 1, 1'b0); row_fill(300, 339, 1'b1);
    send_frame(ROW, 360, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid.left0", int'(d0_left), 0);
    chk("rst_mid.right0", int'(d0_right), 0);
    chk("rst_mid.lslot0", int'(d0_ls), 0);
    chk("rst_mid.left1", int'(d1_left), 0);
    repeat (4) @(negedge clk);
    chk("rst_mid.done0", int'(d0_done), 0);
    last_left0 = 0;

    // Full frame after reset.
    e = mk(300, 340, 7, 8, 8, 1, 1); e.b2w[0] = 300; e.w2b[1] = 340;
    q0.push_back(e); q1.push_back(e);
    send_frame(H - 1, W - 1, 1'b1);
    last_left0 = 300;

    // Candidate still pending at the end of the line is discarded.
    row_fill(0, W - 1, 1'b0); row_fill(638, 639, 1'b1);
    q0.push_back(mk(0, 0, 0, 0, 0, 0, 0));
    q1.push_back(mk(638, 638, 15, 15, 15, 1, 0));
    send_frame(H - 1, W - 1, 1'b1);

    repeat (4) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
